muladd_arbiter: RTL and testbench
=================================

Name: muladd_arbiter

Overview:
- Arbitrates between N requesters for one shared add/multiply datapath and sequences the operation.
- Add completes in one execute cycle. Multiply is an iterative shift-add over W execute cycles.
- Sits between the testbench/task-level requesters and the shared arithmetic unit; the unit is serialized, one operation in flight at a time.

Parameters:
W, 8, operand width; result is 2W bits
N, 4, number of requesters
IDW, 2, width of grant id; must satisfy 2**IDW >= N

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
req  input  N  per-requester request level
op  input  N  per-requester opcode: 0 = add, 1 = multiply
a_bus  input  N*W  packed operand A; requester i uses bits [i*W +: W]
b_bus  input  N*W  packed operand B, packed the same way
ack  output  N  one-cycle completion pulse to the granted requester
result  output  2W  result of the last completed operation
busy  output  1  high whenever the FSM is not in IDLE
grant_id  output  IDW  id of the current or last granted requester

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, ack=0, result=0, busy=0, grant_id=0, rr_ptr=N-1 so requester 0 wins first. Reset overrides everything, including an operation in progress; an aborted operation never acks.
- FSM states: IDLE, EXEC, DONE.
- IDLE: if any req bit is set at posedge T, grant the first set bit searching rr_ptr+1, rr_ptr+2, ... with wrap modulo N. On that grant:
  - latch a, b, op and id; set grant_id=id and rr_ptr=id;
  - clear acc and the cycle counter;
  - go to EXEC (busy=1 from T+1).
- EXEC, add: acc = a + b, zero-extended to 2W, no truncation; go to DONE. One EXEC cycle.
- EXEC, multiply: each cycle, if b[0] then acc += a shifted left by the count; then b >>= 1 and count++. After W cycles go to DONE. b is held in a shift register, so operands are sampled only at grant.
- DONE: result=acc, ack[grant_id]=1 for exactly this cycle, then go to IDLE.
- Latency from the grant posedge T:
  - add: ack high in cycle T+2;
  - multiply: ack high in cycle T+W+1.
- result holds its value until the next DONE. grant_id holds until the next grant.
- Requesters hold req, op, a and b stable until ack, and must drop req in the cycle after ack.
- If req stays high after ack, that requester is eligible again, but the round-robin order gives every other active requester a turn first.
- req dropped mid-operation: the operation still completes and ack still pulses.
- req changes in EXEC/DONE are ignored; there is no preemption.
- Simultaneous requests: strict round-robin order.
- Idle cycle: there is always one IDLE cycle between DONE and the next EXEC.
- Sustained throughput:
  - add: one operation per 3 cycles;
  - multiply: one operation per W+2 cycles.

Optional Feature:
- Macro: MULADD_ARBITER_PRIO0_EN.
- Defined: in IDLE, requester 0 wins whenever req[0] is set, regardless of rr_ptr. A grant to requester 0 does not update rr_ptr. All other requesters use round-robin as above.
- Not defined: pure round-robin. This logic is absent from the netlist.

Test Plan:
- Reset, then req[0] with op=0, A=9, B=3 held high → ack[0] high at T+2 only, result=16'd12, busy high for 2 cycles.
- req[1] with op=1, A=8, B=9 → ack[1] at T+9, result=16'd72; result still 72 ten idle cycles later.
- req[2] with op=1, A=8'hFF, B=8'hFF → result=16'hFE01; A=0 or B=0 → result=0 after 9 cycles.
- req=4'b1111 from reset, all adds with A=i, B=1, each requester dropping req after its ack → acks in order 0,1,2,3, results 1,2,3,4. Then req=4'b1001 with rr_ptr=3 → grant order 0 then 3.
- rst_n low for one cycle during multiply EXEC cycle 4 → no ack, result=0, busy=0 next cycle; a later request from requester 0 completes normally.
- MULADD_ARBITER_PRIO0_EN defined, req=4'b0110 pending while req[0] asserts → 0 is granted before 1 and 2. Macro undefined → 1 is granted first.

Source files
------------

// File: rtl/muladd_arbiter.sv
// Round-robin arbiter sequencing N requesters onto one shared add / shift-add multiply unit.
// Define MULADD_ARBITER_PRIO0_EN to give requester 0 absolute priority in IDLE.
module muladd_arbiter #(
   parameter int W   = 8,
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     op,
   input  logic [N*W-1:0]   a_bus,
   input  logic [N*W-1:0]   b_bus,
   output logic [N-1:0]     ack,
   output logic [2*W-1:0]   result,
   output logic             busy,
   output logic [IDW-1:0]   grant_id
);

   localparam int RW = 2 * W;
   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t          state, state_nxt;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  pick_id;
   logic            pick_valid;
   logic [W-1:0]    a_sel, b_sel;
   logic            op_sel;
   logic [W-1:0]    a_q, b_q;
   logic            op_q;
   logic [RW-1:0]   acc, acc_nxt;
   logic [CW-1:0]   cnt;
   logic            last;

   // Lowest rotated distance from rr_ptr+1 wins.
   always_comb begin
      int unsigned best;
      int unsigned off;
      best       = N;
      off        = 0;
      pick_id    = '0;
      pick_valid = |req;
      for (int unsigned k = 0; k < N; k++) begin
         if (req[k]) begin
            off = (k + N - 32'(rr_ptr) - 1) % N;
            if (off < best) begin
               best    = off;
               pick_id = IDW'(k);
            end
         end
      end
`ifdef MULADD_ARBITER_PRIO0_EN
      if (req[0]) pick_id = '0;
`endif
   end

   always_comb begin
      a_sel  = '0;
      b_sel  = '0;
      op_sel = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (pick_id == IDW'(k)) begin
            a_sel  = a_bus[k*W +: W];
            b_sel  = b_bus[k*W +: W];
            op_sel = op[k];
         end
      end
   end

   assign last = !op_q || (cnt == CW'(W - 1));

   always_comb begin
      if (op_q) begin
         acc_nxt = acc;
         if (b_q[0]) acc_nxt = acc + (RW'(a_q) << cnt);
      end else begin
         acc_nxt = RW'(a_q) + RW'(b_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = EXEC;
         EXEC:    if (last)       state_nxt = DONE;
         DONE:                    state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      ack  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (state == DONE && grant_id == IDW'(k)) ack[k] = 1'b1;
      end
   end

   // result is written on the final EXEC edge so it is valid alongside ack in DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_id <= '0;
         rr_ptr   <= IDW'(N - 1);
         result   <= '0;
         acc      <= '0;
         cnt      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  a_q      <= a_sel;
                  b_q      <= b_sel;
                  op_q     <= op_sel;
                  grant_id <= pick_id;
`ifdef MULADD_ARBITER_PRIO0_EN
                  if (pick_id != '0) rr_ptr <= pick_id;
`else
                  rr_ptr   <= pick_id;
`endif
                  acc      <= '0;
                  cnt      <= '0;
               end
            end
            EXEC: begin
               acc <= acc_nxt;
               b_q <= b_q >> 1;
               cnt <= cnt + 1'b1;
               if (last) result <= acc_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muladd_arbiter.sv
// Scoreboard bench for muladd_arbiter: expected id/result pushed at drive time, popped on ack.
// Expected grant order in the priority scenario follows MULADD_ARBITER_PRIO0_EN.
module tb_muladd_arbiter;

   localparam int W   = 8;
   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int RW  = 2 * W;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req;
   logic [N-1:0]     op;
   logic [N*W-1:0]   a_bus;
   logic [N*W-1:0]   b_bus;
   logic [N-1:0]     ack;
   logic [RW-1:0]    result;
   logic             busy;
   logic [IDW-1:0]   grant_id;

   typedef struct {
      int            id;
      logic [RW-1:0] res;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   muladd_arbiter #(.W(W), .N(N), .IDW(IDW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .op       (op),
      .a_bus    (a_bus),
      .b_bus    (b_bus),
      .ack      (ack),
      .result   (result),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   task automatic drive(input int id, input bit o, input logic [W-1:0] a, input logic [W-1:0] b);
      op[id]           = o;
      a_bus[id*W +: W] = a;
      b_bus[id*W +: W] = b;
      req[id]          = 1'b1;
   endtask

   task automatic push_exp(input int id, input bit o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.id  = id;
      e.res = o ? RW'(a) * RW'(b) : RW'(a) + RW'(b);
      sb.push_back(e);
   endtask

   task automatic wait_ack(output int lat, output int busy_cyc, output bit timed_out);
      lat       = 0;
      busy_cyc  = 0;
      timed_out = 1'b1;
      for (int i = 0; i < 100 && timed_out; i++) begin
         @(negedge clk);
         lat++;
         if (busy) busy_cyc++;
         if (ack != '0) timed_out = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      req   = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = '0;
      op    = '0;
      a_bus = '0;
      b_bus = '0;
      repeat (2) @(negedge clk);
      vectors++; if (ack !== '0) begin miscompares++; $display("FAIL reset_ack got %b want 0", ack); end
      vectors++; if (result !== '0) begin miscompares++; $display("FAIL reset_result got %h want 0", result); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (grant_id !== '0) begin miscompares++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      int lat, bc; bit to; exp_t e; logic [N-1:0] want;
      drive(0, 1'b0, 8'd9, 8'd3);
      push_exp(0, 1'b0, 8'd9, 8'd3);
      wait_ack(lat, bc, to);
      vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL add_timeout got timeout want ack"); end
      e = sb.pop_front();
      want = '0; want[e.id] = 1'b1;
      vectors++; if (ack !== want) begin miscompares++; $display("FAIL add_ack got %b want %b", ack, want); end
      vectors++; if (result !== e.res) begin miscompares++; $display("FAIL add_result got %h want %h", result, e.res); end
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL add_latency got %0d want 2", lat); end
      vectors++; if (bc !== 2) begin miscompares++; $display("FAIL add_busy_cycles got %0d want 2", bc); end
      req[0] = 1'b0;
      @(negedge clk);
      vectors++; if (ack !== '0) begin miscompares++; $display("FAIL add_ack_single got %b want 0", ack); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL add_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_multiply();
      int lat, bc; bit to; exp_t e; logic [N-1:0] want; bit stray;
      drive(1, 1'b1, 8'd8, 8'd9);
      push_exp(1, 1'b1, 8'd8, 8'd9);
      wait_ack(lat, bc, to);
      vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL mul_timeout got timeout want ack"); end
      e = sb.pop_front();
      want = '0; want[e.id] = 1'b1;
      vectors++; if (ack !== want) begin miscompares++; $display("FAIL mul_ack got %b want %b", ack, want); end
      vectors++; if (result !== e.res) begin miscompares++; $display("FAIL mul_result got %h want %h", result, e.res); end
      vectors++; if (lat !== W + 1) begin miscompares++; $display("FAIL mul_latency got %0d want %0d", lat, W + 1); end
      vectors++; if (grant_id !== 2'd1) begin miscompares++; $display("FAIL mul_grant_id got %0d want 1", grant_id); end
      req[1] = 1'b0;
      stray  = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (ack != '0) stray = 1'b1;
      end
      vectors++; if (result !== 16'd72) begin miscompares++; $display("FAIL mul_hold got %h want 0048", result); end
      vectors++; if (stray !== 1'b0) begin miscompares++; $display("FAIL mul_idle_ack got %b want 0", stray); end
   endtask

   task automatic test_multiply_edges();
      logic [W-1:0] av [3];
      logic [W-1:0] bv [3];
      int lat, bc; bit to; exp_t e;
      av[0] = 8'hFF; bv[0] = 8'hFF;
      av[1] = 8'h00; bv[1] = 8'h5A;
      av[2] = 8'hC3; bv[2] = 8'h00;
      for (int i = 0; i < 3; i++) begin
         drive(2, 1'b1, av[i], bv[i]);
         push_exp(2, 1'b1, av[i], bv[i]);
         wait_ack(lat, bc, to);
         e = sb.pop_front();
         vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL edge%0d_timeout got timeout want ack", i); end
         vectors++; if (result !== e.res) begin miscompares++; $display("FAIL edge%0d_result got %h want %h", i, result, e.res); end
         vectors++; if (lat !== W + 1) begin miscompares++; $display("FAIL edge%0d_latency got %0d want %0d", i, lat, W + 1); end
         req[2] = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_round_robin();
      int lat, bc; bit to; exp_t e; logic [N-1:0] want;
      pulse_reset();
      for (int i = 0; i < N; i++) drive(i, 1'b0, W'(i), 8'd1);
      for (int i = 0; i < N; i++) push_exp(i, 1'b0, W'(i), 8'd1);
      for (int n = 0; n < N + 2; n++) begin
         if (n == N) begin
            drive(0, 1'b0, 8'h10, 8'd1);
            drive(3, 1'b0, 8'h30, 8'd1);
            push_exp(0, 1'b0, 8'h10, 8'd1);
            push_exp(3, 1'b0, 8'h30, 8'd1);
         end
         wait_ack(lat, bc, to);
         e = sb.pop_front();
         want = '0; want[e.id] = 1'b1;
         vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL rr%0d_timeout got timeout want ack", n); end
         vectors++; if (ack !== want) begin miscompares++; $display("FAIL rr%0d_ack got %b want %b", n, ack, want); end
         vectors++; if (result !== e.res) begin miscompares++; $display("FAIL rr%0d_result got %h want %h", n, result, e.res); end
         vectors++; if (grant_id !== IDW'(e.id)) begin miscompares++; $display("FAIL rr%0d_grant_id got %0d want %0d", n, grant_id, e.id); end
         req[e.id] = 1'b0;
         if (n == N - 1) @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int lat, bc; bit to; exp_t e; bit stray;
      drive(0, 1'b1, 8'd5, 8'd7);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      @(negedge clk);
      vectors++; if (ack !== '0) begin miscompares++; $display("FAIL abort_ack got %b want 0", ack); end
      vectors++; if (result !== '0) begin miscompares++; $display("FAIL abort_result got %h want 0", result); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
      rst_n = 1'b1;
      stray = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (ack != '0 || busy) stray = 1'b1;
      end
      vectors++; if (stray !== 1'b0) begin miscompares++; $display("FAIL abort_stray got %b want 0", stray); end
      drive(0, 1'b1, 8'd3, 8'd4);
      push_exp(0, 1'b1, 8'd3, 8'd4);
      wait_ack(lat, bc, to);
      e = sb.pop_front();
      vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL post_abort_timeout got timeout want ack"); end
      vectors++; if (result !== e.res) begin miscompares++; $display("FAIL post_abort_result got %h want %h", result, e.res); end
      vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL post_abort_ack got %b want 0001", ack); end
      req[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_priority();
      int lat, bc; bit to; exp_t e; logic [N-1:0] want;
      pulse_reset();
      drive(0, 1'b0, 8'd2, 8'd2);
      push_exp(0, 1'b0, 8'd2, 8'd2);
      wait_ack(lat, bc, to);
      e = sb.pop_front();
      vectors++; if (result !== e.res) begin miscompares++; $display("FAIL prio_warmup_result got %h want %h", result, e.res); end
      req[0] = 1'b0;
      @(negedge clk);
      drive(0, 1'b0, 8'd1, 8'd1);
      drive(1, 1'b0, 8'd2, 8'd2);
      drive(2, 1'b0, 8'd3, 8'd3);
`ifdef MULADD_ARBITER_PRIO0_EN
      push_exp(0, 1'b0, 8'd1, 8'd1);
      push_exp(1, 1'b0, 8'd2, 8'd2);
      push_exp(2, 1'b0, 8'd3, 8'd3);
`else
      push_exp(1, 1'b0, 8'd2, 8'd2);
      push_exp(2, 1'b0, 8'd3, 8'd3);
      push_exp(0, 1'b0, 8'd1, 8'd1);
`endif
      for (int n = 0; n < 3; n++) begin
         wait_ack(lat, bc, to);
         e = sb.pop_front();
         want = '0; want[e.id] = 1'b1;
         vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL prio%0d_timeout got timeout want ack", n); end
         vectors++; if (ack !== want) begin miscompares++; $display("FAIL prio%0d_ack got %b want %b", n, ack, want); end
         vectors++; if (result !== e.res) begin miscompares++; $display("FAIL prio%0d_result got %h want %h", n, result, e.res); end
         req[e.id] = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add();
      test_multiply();
      test_multiply_edges();
      test_round_robin();
      test_reset_abort();
      test_priority();
      vectors++;
      if (sb.size() !== 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
